// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one downstream APB bus between NUM_MASTERS upstream masters.
// Sequences SETUP/ACCESS for the granted master and aborts stalled accesses with an error.
module apb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_MASTERS-1:0]                 m_psel_i,
    input  logic [NUM_MASTERS-1:0]                 m_penable_i,
    input  logic [NUM_MASTERS-1:0]                 m_pwrite_i,
    input  logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0]  m_paddr_i,
    input  logic [NUM_MASTERS*APB_DATA_WIDTH-1:0]  m_pwdata_i,
    output logic [NUM_MASTERS*APB_DATA_WIDTH-1:0]  m_prdata_o,
    output logic [NUM_MASTERS-1:0]                 m_pready_o,
    output logic [NUM_MASTERS-1:0]                 m_pslverr_o,
    output logic                                   s_psel_o,
    output logic                                   s_penable_o,
    output logic                                   s_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]              s_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]              s_pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]              s_prdata_i,
    input  logic                                   s_pready_i,
    input  logic                                   s_pslverr_i,
    output logic                                   timeout_o
);

    // state  | meaning
    // IDLE   | no transfer downstream; arbitrate among requesters
    // SETUP  | downstream SETUP phase for gnt_q
    // ACCESS | downstream ACCESS phase; wait for pready or timeout

    localparam int GW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   pick;
    logic            busy;
    logic            in_access;
    logic            timeout_hit;
    logic            unused_penable;

    logic [APB_ADDR_WIDTH-1:0] paddr_a  [NUM_MASTERS];
    logic [APB_DATA_WIDTH-1:0] pwdata_a [NUM_MASTERS];

    assign unused_penable = ^m_penable_i;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            paddr_a[i]  = m_paddr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            pwdata_a[i] = m_pwdata_i[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        end
    end

    // Lowest-priority group (index <= last) first, then the group above last overrides,
    // so the winner is the first requester in the order last+1 .. last.
    always_comb begin
        pick = '0;
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (m_psel_i[j] && (j <= int'(last_q))) pick = GW'(j);
        end
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (m_psel_i[j] && (j > int'(last_q))) pick = GW'(j);
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign in_access   = (state_q == S_ACCESS);
    assign timeout_hit = TO_EN && in_access && !s_pready_i && (cnt_q == CNT_LAST);
    assign timeout_o   = timeout_hit;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|m_psel_i) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (s_pready_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (timeout_hit) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= GW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields come straight from the granted master; APB holds them stable.
    always_comb begin
        s_psel_o    = busy;
        s_penable_o = in_access;
        s_pwrite_o  = busy ? m_pwrite_i[gnt_q] : 1'b0;
        s_paddr_o   = busy ? paddr_a[gnt_q] : '0;
        s_pwdata_o  = busy ? pwdata_a[gnt_q] : '0;
    end

    always_comb begin
        m_prdata_o  = '0;
        m_pready_o  = '0;
        m_pslverr_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (in_access && (gnt_q == GW'(i))) begin
                m_pready_o[i]  = s_pready_i | timeout_hit;
                m_pslverr_o[i] = (s_pready_i & s_pslverr_i) | timeout_hit;
                m_prdata_o[i*APB_DATA_WIDTH +: APB_DATA_WIDTH] = timeout_hit ? '0 : s_prdata_i;
            end
        end
    end

endmodule
